// File: rtl/wb_regfile_if.sv
// Bundles the MEM/WB writeback fields, the ID-stage read ports and the retire count.
// The master drives W-stage fields and decode indices; the slave is the register file.
interface wb_regfile_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 64
);
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic             ValidW;
    logic             RegWriteW;
    logic [1:0]       ResultSrcW;
    logic [XLEN-1:0]  ALUResultW;
    logic [XLEN-1:0]  ReadDataW;
    logic [AW-1:0]    RdW;
    logic [XLEN-1:0]  PCPlus4W;
    logic [AW-1:0]    Rs1D;
    logic [AW-1:0]    Rs2D;
    logic [XLEN-1:0]  RD1D;
    logic [XLEN-1:0]  RD2D;
    logic [XLEN-1:0]  ResultW;
    logic [CNT_W-1:0] InstRetW;

    modport master (
        output ValidW, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, Rs1D, Rs2D,
        input  RD1D, RD2D, ResultW, InstRetW
    );

    modport slave (
        input  ValidW, RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCPlus4W, Rs1D, Rs2D,
        output RD1D, RD2D, ResultW, InstRetW
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects the W-stage result, commits it to the integer register file,
// serves two bypassed decode read ports and counts retired instructions.
module wb_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    wb_regfile_if.slave   bus
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic [XLEN-1:0]  result;
    logic             commit;

    always_comb begin
        case (bus.ResultSrcW)
            2'b01:   result = bus.ReadDataW;
            2'b10:   result = bus.PCPlus4W;
            // 2'b11 is reserved and falls back to the ALU result
            default: result = bus.ALUResultW;
        endcase
    end

    assign bus.ResultW = result;
    assign commit      = bus.ValidW & bus.RegWriteW & (bus.RdW != '0);

    // Same-cycle bypass lets ID read a value being committed this cycle
    always_comb begin
        bus.RD1D = regs_q[bus.Rs1D];
        if (commit && (bus.RdW == bus.Rs1D)) begin
            bus.RD1D = result;
        end
        if (bus.Rs1D == '0) begin
            bus.RD1D = '0;
        end
    end

    always_comb begin
        bus.RD2D = regs_q[bus.Rs2D];
        if (commit && (bus.RdW == bus.Rs2D)) begin
            bus.RD2D = result;
        end
        if (bus.Rs2D == '0) begin
            bus.RD2D = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[bus.RdW] <= result;
        end
    end

    // Every non-bubble slot retires, whether or not it writes a register
    always_comb begin
        instret_d = instret_q;
        if (bus.ValidW) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign bus.InstRetW = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and model-checked bench for wb_regfile, plus a 4-bit counter build for wrap.
module tb_wb_regfile;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    wb_regfile_if #(.XLEN(32), .NREGS(32), .CNT_W(64)) bus ();
    wb_regfile_if #(.XLEN(32), .NREGS(32), .CNT_W(4))  bus4 ();

    wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(4)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_res [4] = '{32'h11, 32'h22, 32'h33, 32'h11};
    logic [9:0]  vpat = 10'b1101101101;
    logic [31:0] m [32];
    logic [63:0] m_cnt;
    logic [31:0] m_res;
    logic        m_commit;
    logic [31:0] e1, e2;

    initial begin
        bus.ValidW = 0; bus.RegWriteW = 0; bus.ResultSrcW = 0;
        bus.ALUResultW = 0; bus.ReadDataW = 0; bus.PCPlus4W = 0;
        bus.RdW = 0; bus.Rs1D = 0; bus.Rs2D = 0;
        bus4.ValidW = 0; bus4.RegWriteW = 0; bus4.ResultSrcW = 0;
        bus4.ALUResultW = 0; bus4.ReadDataW = 0; bus4.PCPlus4W = 0;
        bus4.RdW = 0; bus4.Rs1D = 0; bus4.Rs2D = 0;

        #12 reset_n = 1'b1;
        bus.Rs1D = 5; bus.Rs2D = 31;
        #1;
        check("reset_rd1", 64'(bus.RD1D), 64'h0);
        check("reset_rd2", 64'(bus.RD2D), 64'h0);
        check("reset_instret", bus.InstRetW, 64'd0);

        // Result select and commit into x5
        bus.RegWriteW = 1; bus.RdW = 5;
        bus.ALUResultW = 32'h11; bus.ReadDataW = 32'h22; bus.PCPlus4W = 32'h33;
        for (int s = 0; s < 4; s++) begin
            bus.ValidW = 1; bus.ResultSrcW = 2'(s);
            #1;
            check($sformatf("resultw_src%0d", s), 64'(bus.ResultW), 64'(exp_res[s]));
            tick();
            bus.ValidW = 0;
            #1;
            check($sformatf("x5_after_src%0d", s), 64'(bus.RD1D), 64'(exp_res[s]));
        end
        check("instret_after_select", bus.InstRetW, 64'd4);

        // Both ports bypass the in-flight x7 write
        bus.ResultSrcW = 0; bus.ALUResultW = 32'hDEADBEEF; bus.RdW = 7;
        bus.Rs1D = 7; bus.Rs2D = 7;
        #1;
        check("x7_before", 64'(bus.RD1D), 64'h0);
        bus.ValidW = 1;
        #1;
        check("bypass_rd1", 64'(bus.RD1D), 64'hDEADBEEF);
        check("bypass_rd2", 64'(bus.RD2D), 64'hDEADBEEF);
        tick();
        bus.ValidW = 0;
        #1;
        check("x7_after_rd1", 64'(bus.RD1D), 64'hDEADBEEF);
        check("x7_after_rd2", 64'(bus.RD2D), 64'hDEADBEEF);

        // x0 write is dropped
        bus.ValidW = 1; bus.RdW = 0; bus.ALUResultW = 32'hFFFFFFFF; bus.Rs1D = 0;
        #1;
        check("x0_bypass", 64'(bus.RD1D), 64'h0);
        tick();
        bus.ValidW = 0;
        #1;
        check("x0_after", 64'(bus.RD1D), 64'h0);
        check("instret_after_x0", bus.InstRetW, 64'd6);

        // Bubble write to x3 is dropped and does not retire
        bus.RdW = 3; bus.ALUResultW = 32'hA5A5A5A5; bus.Rs1D = 3;
        #1;
        check("bubble_no_bypass", 64'(bus.RD1D), 64'h0);
        tick();
        check("bubble_x3", 64'(bus.RD1D), 64'h0);
        check("bubble_instret", bus.InstRetW, 64'd6);

        // Retire pattern 1101101101 adds 7
        bus.RegWriteW = 0;
        for (int i = 9; i >= 0; i--) begin
            bus.ValidW = vpat[i];
            tick();
        end
        bus.ValidW = 0;
        check("instret_pattern", bus.InstRetW, 64'd13);

        // 4-bit counter wraps from 15 to 0
        bus4.ValidW = 1;
        for (int i = 0; i < 15; i++) tick();
        bus4.ValidW = 0;
        check("cnt4_at15", 64'(bus4.InstRetW), 64'd15);
        bus4.ValidW = 1;
        tick();
        bus4.ValidW = 0;
        check("cnt4_wrap", 64'(bus4.InstRetW), 64'd0);

        // Asynchronous reset pulse between edges
        bus.Rs1D = 5; bus.Rs2D = 7;
        #1;
        check("pre_reset_x5", 64'(bus.RD1D), 64'h11);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_instret", bus.InstRetW, 64'd0);
        check("async_reset_x7", 64'(bus.RD2D), 64'h0);
        #1 reset_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            bus.Rs1D = 5'(r); bus.Rs2D = 5'(31 - r);
            #1;
            check($sformatf("reset_all_rd1_x%0d", r), 64'(bus.RD1D), 64'h0);
            check($sformatf("reset_all_rd2_x%0d", 31 - r), 64'(bus.RD2D), 64'h0);
        end
        check("reset_instret_after", bus.InstRetW, 64'd0);

        // Random traffic against a reference model
        for (int i = 0; i < 32; i++) m[i] = '0;
        m_cnt = '0;
        tick();
        for (int n = 0; n < 10000; n++) begin
            bus.ValidW     = ($urandom_range(0, 3) != 0);
            bus.RegWriteW  = $urandom_range(0, 1) == 1;
            bus.ResultSrcW = 2'($urandom_range(0, 3));
            bus.ALUResultW = $urandom;
            bus.ReadDataW  = $urandom;
            bus.PCPlus4W   = $urandom;
            bus.RdW        = 5'($urandom_range(0, 7));
            bus.Rs1D       = 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            bus.Rs2D       = 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            case (bus.ResultSrcW)
                2'b01:   m_res = bus.ReadDataW;
                2'b10:   m_res = bus.PCPlus4W;
                default: m_res = bus.ALUResultW;
            endcase
            m_commit = bus.ValidW && bus.RegWriteW && (bus.RdW != 0);
            e1 = (bus.Rs1D == 0) ? 32'h0 : (m_commit && bus.RdW == bus.Rs1D) ? m_res : m[bus.Rs1D];
            e2 = (bus.Rs2D == 0) ? 32'h0 : (m_commit && bus.RdW == bus.Rs2D) ? m_res : m[bus.Rs2D];
            #1;
            check("rand_resultw", 64'(bus.ResultW), 64'(m_res));
            check("rand_rd1", 64'(bus.RD1D), 64'(e1));
            check("rand_rd2", 64'(bus.RD2D), 64'(e2));
            check("rand_instret", bus.InstRetW, m_cnt);
            tick();
            if (m_commit) m[bus.RdW] = m_res;
            if (bus.ValidW) m_cnt = m_cnt + 64'd1;
        end
        bus.ValidW = 0;
        #1;
        check("rand_instret_final", bus.InstRetW, m_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
